// File: rtl/sram_c_drain.sv
// sram_c_drain: streams len bytes of SRAM C from base_addr out on a valid/ready byte port
module sram_c_drain #(
  parameter int AW     = 10,
  parameter int DW     = 8,
  parameter int FIFO_D = 2
) (
  input  logic          rpll_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          sram_C_sel,
  output logic [AW-1:0] sram_C_addr,
  input  logic [DW-1:0] sram_C_dout,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);
  localparam int PW = $clog2(FIFO_D);
  localparam logic [PW:0] DEPTH = FIFO_D[PW:0];
  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t        r_state, w_next;
  logic [AW:0]   r_len, r_issued, r_sent;
  logic [AW-1:0] r_addr;
  logic          r_in_flight, r_done;
  logic [DW-1:0] r_mem [FIFO_D];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt, w_occ;
  logic          w_go, w_pop, w_push, w_issue, w_last;
  // sram_C_addr always presents the next address to read; the SRAM samples it on
  // every edge, and an edge where w_issue holds counts that sample as a read
  assign busy        = r_state == S_RUN;
  assign done        = r_done;
  assign sram_C_sel  = busy;
  assign sram_C_addr = r_addr;
  assign m_valid     = r_cnt != '0;
  assign m_data      = r_mem[r_rp];
  // issue credit counts FIFO entries plus the read whose data lands next edge
  always_comb begin
    w_go    = start && r_state == S_IDLE;
    w_pop   = m_valid && m_ready;
    w_push  = r_in_flight;
    w_occ   = r_cnt + {{PW{1'b0}}, r_in_flight} - {{PW{1'b0}}, w_pop};
    w_issue = r_state == S_RUN && r_issued < r_len && w_occ < DEPTH;
    w_last  = w_pop && r_sent == r_len - 1'b1;
    w_next  = r_state == S_IDLE ? ((w_go && len != '0) ? S_RUN : S_IDLE)
                                : (w_last ? S_IDLE : S_RUN);
  end
  // state register
  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  // address/issue counters, done pulse and prefetch FIFO
  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_addr      <= '0;
      r_in_flight <= 1'b0;
      r_done      <= 1'b0;
      r_wp        <= '0;
      r_rp        <= '0;
      r_cnt       <= '0;
      for (int i = 0; i < FIFO_D; i++) r_mem[i] <= '0;
    end else begin
      r_done      <= (w_go && len == '0) || (r_state == S_RUN && w_last);
      r_in_flight <= w_issue;
      r_cnt       <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      if (w_go && len != '0) begin
        r_addr   <= base_addr;
        r_len    <= len;
        r_issued <= '0;
        r_sent   <= '0;
      end
      if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (w_push) begin
        r_mem[r_wp] <= sram_C_dout;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_sent <= r_sent + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sram_c_drain.sv
// tb_sram_c_drain: directed checks of sram_c_drain against a behavioural SRAM C
module tb_sram_c_drain;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       m_ready = 1'b0;
  logic [9:0] base_addr = '0;
  logic [10:0] len = '0;
  logic       busy, done, sel, m_valid;
  logic [9:0] addr;
  logic [7:0] dout = '0;
  logic [7:0] m_data;
  logic [7:0] mem [1024];
  int n_chk = 0;
  int n_fail = 0;
  int p5;
  int cyc5;
  logic [9:0] addr_before;

  sram_c_drain dut (
    .rpll_clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_C_sel(sel), .sram_C_addr(addr),
    .sram_C_dout(dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) dout <= mem[addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [9:0] b, input logic [10:0] l);
    base_addr = b;
    len = l;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic drain(input logic [9:0] b, input logic [10:0] l, input bit toggle, input bit inject);
    int popped = 0;
    int cyc = 0;
    bit stalled = 0;
    logic [7:0] held = '0;
    logic [9:0] ahead;
    logic [9:0] ea;
    logic [5:0] pat = 6'b101001;
    while (popped < int'(l) && cyc < 300) begin
      m_ready = toggle ? pat[cyc % 6] : 1'b1;
      start = inject && cyc == 3;
      if (inject && cyc == 3) begin
        base_addr = 10'd100;
        len = 11'd3;
      end
      if (stalled) chk("stable", m_data, held);
      if (busy) begin
        ahead = addr - b - 10'(popped);
        chk("ahead_le2", 32'(ahead <= 10'd2), 1);
      end
      if (m_valid && m_ready) begin
        ea = b + 10'(popped);
        chk("beat", m_data, mem[ea]);
        popped++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      tick;
      cyc++;
    end
    start = 1'b0;
    m_ready = 1'b1;
    chk("beats", popped, 32'(l));
    chk("done_end", done, 1);
    chk("busy_end", busy, 0);
    tick;
    chk("done_clear", done, 0);
  endtask

  initial begin
    tick;
    tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel", sel, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    rst_n = 1'b1;
    tick;

    // 1: back-to-back stream with exact latency
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    m_ready = 1'b1;
    kick(10'd0, 11'd4);
    chk("t1_busy", busy, 1);
    chk("t1_sel", sel, 1);
    chk("t1_addr0", addr, 0);
    chk("t1_valid_e0", m_valid, 0);
    tick;
    chk("t1_valid_e1", m_valid, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", m_valid, 1);
      chk("t1_data", m_data, 32'(8'h11 * (i + 1)));
      chk("t1_nodone", done, 0);
      tick;
    end
    chk("t1_done", done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_valid_end", m_valid, 0);
    tick;
    chk("t1_done_clr", done, 0);

    // 2: toggling backpressure
    kick(10'd0, 11'd4);
    drain(10'd0, 11'd4, 1'b1, 1'b0);

    // 3: address wrap
    mem[1022] = 8'hAA; mem[1023] = 8'hBB; mem[0] = 8'hCC;
    kick(10'd1022, 11'd3);
    chk("t3_addr0", addr, 1022);
    drain(10'd1022, 11'd3, 1'b0, 1'b0);

    // 4: zero-length request
    addr_before = addr;
    kick(10'd7, 11'd0);
    chk("t4_done", done, 1);
    chk("t4_busy", busy, 0);
    chk("t4_valid", m_valid, 0);
    chk("t4_addr", addr, 32'(addr_before));
    tick;
    chk("t4_done_clr", done, 0);
    chk("t4_busy2", busy, 0);

    // 5: reset mid-transfer then restart
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
    m_ready = 1'b1;
    kick(10'd0, 11'd1024);
    p5 = 0;
    cyc5 = 0;
    while (p5 < 100 && cyc5 < 200) begin
      if (m_valid) begin
        chk("t5_beat", m_data, mem[p5]);
        p5++;
      end
      tick;
      cyc5++;
    end
    chk("t5_beats", p5, 100);
    rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_sel", sel, 0);
    chk("t5_addr", addr, 0);
    chk("t5_valid", m_valid, 0);
    chk("t5_data", m_data, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("t5_nodone", done, 0);
    kick(10'd5, 11'd2);
    drain(10'd5, 11'd2, 1'b0, 1'b0);

    // 6: start while busy is ignored
    kick(10'd0, 11'd6);
    drain(10'd0, 11'd6, 1'b1, 1'b1);
    tick;
    chk("t6_idle", busy, 0);
    chk("t6_valid", m_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
